// File: rtl/fpmul_param_if.sv
// rtl/fpmul_param_if.sv - Start/Done coprocessor bus for the parametrised FP multiplier
interface fpmul_param_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  localparam int W = 1 + EW + MW;

  logic         start;
  logic [1:0]   rm;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] p;
  logic         uf;
  logic         of;
  logic         nanf;
  logic         inff;
  logic         dnf;
  logic         zf;

  modport master (
    output start, rm, a, b,
    input  busy, done, p, uf, of, nanf, inff, dnf, zf
  );

  modport slave (
    input  start, rm, a, b,
    output busy, done, p, uf, of, nanf, inff, dnf, zf
  );
endinterface

// File: rtl/fpmul_param.sv
// rtl/fpmul_param.sv - multi-cycle shift-add floating-point multiplier with selectable rounding
module fpmul_param #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fpmul_param_if.slave io_fp
);
  localparam int W  = 1 + EW + MW;
  localparam int SW = MW + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [XW-1:0] BIAS   = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EP_MAX = XW'((1 << EW) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;

  logic [2:0]           r_state;
  logic [W-1:0]         r_a, r_b, r_p;
  logic [1:0]           r_rm;
  logic                 r_sp;
  logic [SW-1:0]        r_mcand, r_hi, r_lo, r_sig;
  logic [CW-1:0]        r_cnt;
  logic signed [XW-1:0] r_ep;
  logic                 r_g, r_r, r_s;
  logic                 r_uf, r_of, r_nanf, r_inff, r_dnf, r_zf;

  logic [EW-1:0]        w_ea, w_eb;
  logic [MW-1:0]        w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                 w_sp, w_nan, w_inf, w_special;
  logic [W-1:0]         w_spec_p;
  logic signed [XW-1:0] w_ep_load;
  logic [SW:0]          w_sum;
  logic [PW-1:0]        w_prod, w_norm;
  logic                 w_inc;
  logic [SW:0]          w_rsig;
  logic [MW-1:0]        w_frac;
  logic signed [XW-1:0] w_ep_r;
  logic                 w_of, w_uf, w_ovf_inf;

  // Exponent 0 is treated as zero whether or not the fraction is set (denormals flush)
  assign w_ea     = r_a[W-2:MW];
  assign w_eb     = r_b[W-2:MW];
  assign w_fa     = r_a[MW-1:0];
  assign w_fb     = r_b[MW-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_sp     = r_a[W-1] ^ r_b[W-1];

  assign w_nan     = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
  assign w_inf     = w_a_inf | w_b_inf;
  assign w_special = w_nan | w_inf | w_a_zero | w_b_zero;
  assign w_spec_p  = w_nan ? {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}} :
                     w_inf ? {w_sp, {EW{1'b1}}, {MW{1'b0}}} :
                             {w_sp, {(W-1){1'b0}}};
  assign w_ep_load = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(SW+1){1'b0}});
  assign w_prod = {r_hi, r_lo};
  assign w_norm = w_prod[PW-1] ? w_prod : {w_prod[PW-2:0], 1'b0};

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      RM_RNE:  w_inc = r_g & (r_r | r_s | r_sig[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~r_sp & (r_g | r_r | r_s);
      default: w_inc = r_sp & (r_g | r_r | r_s);
    endcase
  end

  assign w_rsig    = {1'b0, r_sig} + {{SW{1'b0}}, w_inc};
  assign w_frac    = w_rsig[SW] ? w_rsig[MW:1] : w_rsig[MW-1:0];
  assign w_ep_r    = r_ep + {{(XW-1){1'b0}}, w_rsig[SW]};
  assign w_of      = (w_ep_r >= EP_MAX);
  assign w_uf      = (w_ep_r <= $signed({XW{1'b0}}));
  // Saturate to infinity only when the rounding direction points away from zero
  assign w_ovf_inf = (r_rm == RM_RNE) | ((r_rm == RM_RUP) & ~r_sp) | ((r_rm == 2'b11) & r_sp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rm    <= '0;
      r_sp    <= 1'b0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_ep    <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
      r_p     <= '0;
      r_uf    <= 1'b0;
      r_of    <= 1'b0;
      r_nanf  <= 1'b0;
      r_inff  <= 1'b0;
      r_dnf   <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_fp.start) begin
            r_a     <= io_fp.a;
            r_b     <= io_fp.b;
            r_rm    <= io_fp.rm;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sp    <= w_sp;
          r_mcand <= {1'b1, w_fa};
          r_hi    <= '0;
          r_lo    <= {1'b1, w_fb};
          r_cnt   <= '0;
          r_ep    <= w_ep_load;
          if (w_special) begin
            r_p     <= w_spec_p;
            r_uf    <= 1'b0;
            r_of    <= 1'b0;
            r_nanf  <= w_nan;
            r_inff  <= ~w_nan & w_inf;
            r_zf    <= ~w_nan & ~w_inf;
            r_dnf   <= (w_a_zero & (|w_fa)) | (w_b_zero & (|w_fb));
            r_state <= S_DONE;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_hi  <= w_sum[SW:1];
          r_lo  <= {w_sum[0], r_lo[SW-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(SW - 1)) r_state <= S_NORM;
        end
        S_NORM: begin
          r_sig   <= w_norm[PW-1 -: SW];
          r_g     <= w_norm[PW-1-SW];
          r_r     <= w_norm[PW-2-SW];
          r_s     <= |w_norm[PW-3-SW:0];
          r_ep    <= r_ep + {{(XW-1){1'b0}}, w_prod[PW-1]};
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_uf   <= 1'b0;
          r_of   <= 1'b0;
          r_nanf <= 1'b0;
          r_inff <= 1'b0;
          r_dnf  <= 1'b0;
          r_zf   <= 1'b0;
          if (w_of) begin
            r_of   <= 1'b1;
            r_inff <= w_ovf_inf;
            r_p    <= w_ovf_inf ? {r_sp, {EW{1'b1}}, {MW{1'b0}}}
                                : {r_sp, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
          end else if (w_uf) begin
            r_uf <= 1'b1;
            r_zf <= 1'b1;
            r_p  <= {r_sp, {(W-1){1'b0}}};
          end else begin
            r_p  <= {r_sp, w_ep_r[EW-1:0], w_frac};
          end
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_fp.busy = (r_state == S_LOAD) | (r_state == S_MUL) |
                      (r_state == S_NORM) | (r_state == S_ROUND);
  assign io_fp.done = (r_state == S_DONE);
  assign io_fp.p    = r_p;
  assign io_fp.uf   = r_uf;
  assign io_fp.of   = r_of;
  assign io_fp.nanf = r_nanf;
  assign io_fp.inff = r_inff;
  assign io_fp.dnf  = r_dnf;
  assign io_fp.zf   = r_zf;
endmodule

// File: tb/tb_fpmul_param.sv
// tb/tb_fpmul_param.sv - directed-vector bench for fpmul_param (single and half precision instances)
module tb_fpmul_param;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fpmul_param_if #(.EW(8), .MW(23)) f32 ();
  fpmul_param_if #(.EW(5), .MW(10)) f16 ();

  fpmul_param #(.EW(8), .MW(23)) u_f32 (.i_clk(clk), .i_rst(rst), .io_fp(f32));
  fpmul_param #(.EW(5), .MW(10)) u_f16 (.i_clk(clk), .i_rst(rst), .io_fp(f16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags(input bit h);
    if (h) return {f16.uf, f16.of, f16.nanf, f16.inff, f16.dnf, f16.zf};
    return {f32.uf, f32.of, f32.nanf, f32.inff, f32.dnf, f32.zf};
  endfunction

  // Issue one operation; returns the Done cycle (-1 on timeout) and number of Busy cycles
  task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] rm, output int dcyc, output int bcnt);
    @(negedge clk);
    if (h) begin
      f16.a = a[15:0]; f16.b = b[15:0]; f16.rm = rm; f16.start = 1'b1;
    end else begin
      f32.a = a; f32.b = b; f32.rm = rm; f32.start = 1'b1;
    end
    @(negedge clk);
    f16.start = 1'b0; f32.start = 1'b0;
    f16.a = '1; f16.b = '1; f32.a = '1; f32.b = '1; f16.rm = ~rm; f32.rm = ~rm;
    dcyc = -1;
    bcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      if (h ? f16.done : f32.done) begin
        dcyc = n;
        break;
      end
      if (h ? f16.busy : f32.busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic vec(input string tag, input bit h, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] rm, input logic [31:0] exp_p, input logic [5:0] exp_fl,
                     input int exp_dc);
    int dc, bc;
    op(h, a, b, rm, dc, bc);
    chk({tag, ".done_cycle"}, dc, exp_dc);
    chk({tag, ".busy_cycles"}, bc, exp_dc - 1);
    chk({tag, ".p"}, h ? {16'h0, f16.p} : f32.p, exp_p);
    chk({tag, ".flags"}, flags(h), exp_fl);
  endtask

  initial begin
    int ndone, first;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    f32.start = 1'b0; f32.rm = 2'b00; f32.a = '0; f32.b = '0;
    f16.start = 1'b0; f16.rm = 2'b00; f16.a = '0; f16.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset.p", f32.p, 32'h0);
    chk("reset.flags", flags(1'b0), 6'b0);
    chk("reset.busy_done", {f32.busy, f32.done, f16.busy, f16.done}, 4'b0);

    // flags order: {UF, OF, NaNF, InfF, DNF, ZF}
    vec("rne_3x2p5",   0, 32'h40400000, 32'h40200000, 2'b00, 32'h40F00000, 6'b000000, 28);
    vec("inf_x_zero",  0, 32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 6'b001000, 2);
    vec("ninf_x_one",  0, 32'hFF800000, 32'h3F800000, 2'b00, 32'hFF800000, 6'b000100, 2);
    vec("denorm_x1",   0, 32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, 6'b000011, 2);
    vec("ovf_rne",     0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 6'b010100, 28);
    vec("ovf_rtz",     0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 6'b010000, 28);
    vec("ovf_rup",     0, 32'h7F000000, 32'h7F000000, 2'b10, 32'h7F800000, 6'b010100, 28);
    vec("ovf_rdn",     0, 32'h7F000000, 32'h7F000000, 2'b11, 32'h7F7FFFFF, 6'b010000, 28);
    vec("ovf_rdn_neg", 0, 32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, 6'b010100, 28);
    vec("unf",         0, 32'h00800000, 32'h00800000, 2'b00, 32'h00000000, 6'b100001, 28);
    vec("rnd_rne",     0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 6'b000000, 28);
    vec("rnd_rtz",     0, 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 6'b000000, 28);
    vec("rnd_rup",     0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 6'b000000, 28);
    vec("rnd_rdn_neg", 0, 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 6'b000000, 28);
    vec("h_one_x_two", 1, 32'h3C00, 32'h4000, 2'b00, 32'h4000, 6'b000000, 15);
    vec("h_ovf_rne",   1, 32'h7BFF, 32'h7BFF, 2'b00, 32'h7C00, 6'b010100, 15);

    // Second Start while busy is ignored
    @(negedge clk);
    f32.a = 32'h40400000; f32.b = 32'h40200000; f32.rm = 2'b00; f32.start = 1'b1;
    @(negedge clk);
    ndone = 0;
    first = -1;
    for (int n = 1; n <= 60; n++) begin
      f32.start = (n == 5);
      if (f32.done) begin
        ndone++;
        if (first < 0) first = n;
      end
      @(negedge clk);
    end
    f32.start = 1'b0;
    chk("restart.done_count", ndone, 1);
    chk("restart.done_cycle", first, 28);
    chk("restart.p", f32.p, 32'h40F00000);

    // Reset mid-operation aborts with no Done and clears outputs
    f32.a = 32'h7F000000; f32.b = 32'h7F000000; f32.rm = 2'b00; f32.start = 1'b1;
    @(negedge clk);
    f32.start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      rst = (n == 10);
      if (f32.done) ndone++;
      @(negedge clk);
    end
    rst = 1'b0;
    chk("abort.done_count", ndone, 0);
    chk("abort.p", f32.p, 32'h0);
    chk("abort.flags", flags(1'b0), 6'b0);
    chk("abort.busy", f32.busy, 1'b0);

    vec("post_reset", 0, 32'h40400000, 32'h40200000, 2'b00, 32'h40F00000, 6'b000000, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fpmul_param.md
# fpmul_param

Parametrised multi-cycle IEEE-754-style floating-point multiplier; next generation of the fixed single-precision FPMUL. Exponent and fraction widths are set per instance, four rounding modes are selectable per operation, and a Busy output is added. Sits beside the ALU as a Start/Done coprocessor, split internally into control unit and datapath.

## Interface
- EW, 8, exponent field width (3..11); BIAS = 2^(EW-1)-1
- MW, 23, fraction field width (4..52); operand width W = 1+EW+MW
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only in IDLE
- RM  in  2  rounding mode, latched with operands: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- A, B  in  W  operands, latched at Start; may change afterwards
- Busy  out  1  high from the cycle after Start is accepted until Done
- Done  out  1  one-cycle pulse; P and flags valid from this cycle
- P  out  W  product; held until next Done
- UF, OF, NaNF, InfF, DNF, ZF  out  1  underflow, overflow, NaN result, infinite result, denormal operand flushed, zero result; held with P

## Operation
- States: IDLE -> LOAD -> (special ? DONE : MUL) ; MUL (MW+1 cycles) -> NORM -> ROUND -> DONE -> IDLE.
- LOAD: unpack sign/exp/fraction; exp 0 with fraction ≠ 0 is flushed to zero, DNF=1; SP = SA^SB.
- Special cases resolved in LOAD, priority order: any NaN operand or Inf×0 -> canonical qNaN {0, all-ones exp, 1, zeros}, NaNF; Inf×finite -> signed Inf, InfF; zero×finite -> signed zero, ZF.
- MUL: shift-add, one multiplier bit per cycle into 2(MW+1)-bit product register (high/low halves). Exponent EP = EA+EB-BIAS in EW+2-bit signed arithmetic.
- NORM: if product MSB set, shift right 1, EP+1. Extract LSB, guard G, round R, sticky S (OR of remaining bits).
- ROUND: increment when RNE: G&(R|S|LSB); RTZ: never; RUP: ~SP&(G|R|S); RDN: SP&(G|R|S). Carry out of significand -> shift right, EP+1.
- Overflow (EP ≥ 2^EW-1): OF=1; RNE -> signed Inf, InfF=1; RTZ -> signed max finite; RUP -> +Inf if positive else -max finite; RDN mirror. InfF set only when Inf output.
- Underflow (EP ≤ 0): no denormal output; result signed zero, UF=1, ZF=1.
- Exact zero product never occurs in normal path (zeros handled as special).

## Timing
- Reset: state IDLE; P=0, Busy=0, Done=0, all flags 0. Reset mid-operation aborts; no Done is produced.
- Start sampled in cycle 0 (IDLE). Normal path: Done high in cycle MW+5 (28 at defaults). Special path: Done high in cycle 2.
- Busy high cycles 1 through Done cycle-1; low in Done cycle. Start while Busy or in Done cycle ignored.
- Start and Rst together: Rst wins.
- Back-to-back: Start may be asserted the cycle after Done; accepted.
- P/flags change only in Done cycle (or on reset); all flags cleared and recomputed each operation.

## Test plan
- Defaults, RNE: A=0x40400000, B=0x40200000 -> P=0x40F00000, all flags 0, Done exactly 28 cycles after Start, Busy high 27 cycles.
- Specials: 0x7F800000 × 0x00000000 -> 0x7FC00000 NaNF=1, Done at cycle 2; 0xFF800000 × 0x3F800000 -> 0xFF800000 InfF=1; 0x00000001 × 0x3F800000 -> 0x00000000 DNF=1 ZF=1.
- Overflow: 0x7F000000 × 0x7F000000 -> RNE 0x7F800000 OF=1 InfF=1; RTZ 0x7F7FFFFF OF=1 InfF=0; RDN 0x7F7FFFFF.
- Underflow/rounding: 0x00800000 × 0x00800000 -> 0x00000000 UF=1 ZF=1; 0x3F800001 × 0x3F800001 -> RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003; negated A under RDN -> 0xBF800003.
- Handshake: Start pulsed again at cycle 5 ignored (single Done); Rst at cycle 10 -> no Done, outputs zero; new Start after reset completes normally.
- EW=5, MW=10 instance: 0x3C00 × 0x4000 -> 0x4000, Done at cycle 15; 0x7BFF × 0x7BFF RNE -> 0x7C00 OF=1 InfF=1.
